soc_test_ctrl: RTL
==================

Name: soc_test_ctrl

Overview:
Synthesizable run-control block for the rv32i SoC: it replaces fixed-delay reset and stop-time control with a parametrised sequencer. It stretches reset to the core, counts cycles and retired instructions, and detects test completion via a store to a tohost address. It also enforces a cycle timeout and raises sticky pass/fail/timeout status that a testbench or FPGA LED/UART wrapper can sample. It sits between the top-level clock/reset and processor_top, snooping the core's data-memory write port.

Parameters:
RST_CYCLES, 2, cycles core_rst stays high after rst deasserts (min 1)
TIMEOUT_CYCLES, 50, RUN cycles before timeout (min 2)
CNT_W, 32, width of cycle and instret counters
ADDR_W, 32, data-memory address width
DATA_W, 32, data-memory write-data width
TOHOST_ADDR, 32'h0000_1000, word address whose store ends the test

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
core_rst  out  1  reset to processor_top, stretched
core_halt  out  1  high in DONE; clock-enable/stall to core
retire_valid  in  1  core retired one instruction this cycle
mem_we  in  1  core data-memory write strobe
mem_addr  in  ADDR_W  core data-memory write address
mem_wdata  in  DATA_W  core data-memory write data
running  out  1  high in RUN
done  out  1  sticky, test finished
pass  out  1  sticky, tohost write of 1
fail  out  1  sticky, tohost write of value other than 1
timeout  out  1  sticky, TIMEOUT_CYCLES reached without tohost
exit_code  out  DATA_W-1  mem_wdata[DATA_W-1:1] captured on tohost write
cycle_count  out  CNT_W  RUN cycles elapsed
instret_count  out  CNT_W  retired instructions during RUN

Behaviour:
- Reset (async, rst=1): state=HOLD; hold counter=0; core_rst=1; core_halt=0; running=0; done, pass, fail, timeout=0; exit_code=0; cycle_count=0; instret_count=0.
- States: HOLD -> RUN -> DONE. DONE is terminal until rst.
- HOLD: core_rst=1. The hold counter increments each clk after rst falls. On the edge where the counter reaches RST_CYCLES-1, state goes to RUN. core_rst therefore falls exactly RST_CYCLES rising edges after rst deasserts.
- RUN: core_rst=0 and running=1.
  - cycle_count increments every cycle.
  - instret_count increments when retire_valid=1.
  - Both counters saturate at all-ones and do not wrap.
- tohost detect: in RUN, mem_we=1 and mem_addr==TOHOST_ADDR. Next edge goes to DONE and latches:
  - pass=(mem_wdata==1).
  - fail=!pass.
  - exit_code=mem_wdata>>1.
  - A write of 0 is a fail with exit_code 0.
- Timeout: in RUN, when cycle_count==TIMEOUT_CYCLES-1 and there is no tohost hit, next edge goes to DONE with timeout=1 and pass=fail=0.
- Simultaneous tohost hit and timeout cycle: the tohost hit wins and timeout stays 0.
- DONE:
  - core_halt=1, running=0, done=1, core_rst=0.
  - Counters freeze.
  - Further mem_we/retire_valid are ignored.
  - Status never changes.
- Inputs are ignored in HOLD, and writes to TOHOST_ADDR in HOLD have no effect.
- Reset mid-RUN or in DONE: immediate return to reset values and a new sequence.
- Exactly one of pass/fail/timeout is 1 whenever done=1. All three are 0 when done=0.
- All outputs are registered. No combinational path from any input to any output.

Decomposition:
- Package soc_test_pkg holds:
  - state encoding (HOLD=2'd0, RUN=2'd1, DONE=2'd2)
  - TOHOST_PASS=1
  - default TOHOST_ADDR
- One sub-module is natural: sat_counter (parametrised width, enable, sync clear, async rst, saturating). It is instantiated for cycle_count, instret_count and the hold counter.
- The processor testbench instantiates soc_test_ctrl and ends the simulation on done, replacing its fixed-delay reset and stop-time blocks.

Test Plan:
- Reset stretch: rst high 20ns then low, RST_CYCLES=2 -> core_rst falls on 2nd rising edge after rst low; running=1 the same edge; all status outputs 0.
- Pass: in RUN, retire_valid pulsed 7 times, then mem_we with addr=0x1000, wdata=1 on cycle 10 -> next edge done=1, pass=1, fail=0, exit_code=0, instret_count=7, cycle_count frozen at 10, core_halt=1.
- Fail code: tohost write wdata=0x0000_0007 -> fail=1, pass=0, exit_code=3; a later write of 1 changes nothing.
- Timeout: no tohost, TIMEOUT_CYCLES=50 -> done=1 and timeout=1 after cycle_count reaches 49; pass=fail=0; a non-tohost write (addr=0x1004) is ignored.
- Simultaneous: tohost write of 1 on the timeout cycle -> pass=1, timeout=0.
- Async reset: assert rst mid-RUN off a clock edge -> core_rst=1, counters and status 0 immediately; the sequence restarts cleanly after deassert.

Source files
------------

// File: rtl/soc_test_pkg.sv
// soc_test_pkg
//   Shared definitions for the SoC run-control block: sequencer state
//   encoding, the tohost value that means "test passed", and the default
//   tohost word address.
package soc_test_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,   // core held in reset while the stretch counter runs
        ST_RUN  = 2'd1,   // core executing, counters live
        ST_DONE = 2'd2    // terminal until rst; status frozen
    } state_e;

    localparam int          TOHOST_PASS         = 1;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/soc_test_ctrl_sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk  : clock
//   rst  : asynchronous active-high reset, clears the count
//   en   : count enable
//   clr  : synchronous clear, wins over en
//   q    : current count (registered)
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/soc_test_ctrl.sv
// soc_test_ctrl
//   Run-control sequencer for the rv32i SoC. Stretches reset to the core,
//   counts RUN cycles and retired instructions, ends the test on a store to
//   the tohost address or on a cycle timeout, and holds sticky status.
//   clk, rst       : system clock, asynchronous active-high reset
//   core_rst       : stretched reset to processor_top
//   core_halt      : stall/clock-enable to the core once the test is done
//   retire_valid   : core retired one instruction this cycle
//   mem_we/addr/wdata : snooped data-memory write port
//   running        : sequencer is in RUN
//   done/pass/fail/timeout : sticky completion status
//   exit_code      : mem_wdata[DATA_W-1:1] of the tohost store
//   cycle_count    : RUN cycles elapsed (saturating)
//   instret_count  : instructions retired during RUN (saturating)
module soc_test_ctrl
    import soc_test_pkg::*;
#(
    parameter int                RST_CYCLES     = 2,
    parameter int                TIMEOUT_CYCLES = 50,
    parameter int                CNT_W          = 32,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              core_rst,
    output logic              core_halt,
    input  logic              retire_valid,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-2:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instret_count
);

    // Hold counter only needs to reach RST_CYCLES-1.
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              in_hold;
    logic              in_run;
    logic              hold_last;
    logic              tohost_hit;
    logic              tmo_hit;

    assign in_hold    = (state == ST_HOLD);
    assign in_run     = (state == ST_RUN);
    assign hold_last  = in_hold && (hold_cnt == HOLD_W'(RST_CYCLES - 1));
    assign tohost_hit = in_run && mem_we && (mem_addr == TOHOST_ADDR);
    // The final RUN cycle is the one that sees TIMEOUT_CYCLES-1; the count
    // still steps on that edge, so it freezes at TIMEOUT_CYCLES.
    assign tmo_hit    = in_run && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .en  (in_hold && !hold_last),
        .clr (1'b0),
        .q   (hold_cnt)
    );

    // Both counters step on every RUN edge, including the one that enters
    // DONE, so the ending cycle is itself counted.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (in_run),
        .clr (1'b0),
        .q   (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk (clk),
        .rst (rst),
        .en  (in_run && retire_valid),
        .clr (1'b0),
        .q   (instret_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_HOLD;
            core_rst  <= 1'b1;
            core_halt <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_last) begin
                        state    <= ST_RUN;
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // tohost takes priority over a coincident timeout.
                    if (tohost_hit) begin
                        state     <= ST_DONE;
                        running   <= 1'b0;
                        core_halt <= 1'b1;
                        done      <= 1'b1;
                        pass      <= (mem_wdata == DATA_W'(TOHOST_PASS));
                        fail      <= (mem_wdata != DATA_W'(TOHOST_PASS));
                        exit_code <= mem_wdata[DATA_W-1:1];
                    end else if (tmo_hit) begin
                        state     <= ST_DONE;
                        running   <= 1'b0;
                        core_halt <= 1'b1;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // terminal: everything frozen until rst
                end
                default: begin
                    state    <= ST_HOLD;
                    core_rst <= 1'b1;
                    running  <= 1'b0;
                end
            endcase
        end
    end

endmodule
